// File: rtl/mips_rf_pkg.sv
// Shared types and defaults for the MIPS register file with scoreboard.
// Optional MIPS_RF_BYPASS_EN (top level) adds write-to-read forwarding.
package mips_rf_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_RD_DEF = 2;

  typedef enum logic [0:0] {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_t;

endpackage

// File: rtl/mips_rf_scoreboard.sv
// Pending-bit vector for long-latency producers: sweep-clear, then set/clear.
// A set wins over a clear that targets the same register in the same cycle.
module mips_rf_scoreboard
  import mips_rf_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                   CLK,
  input  logic                   sweep_en,
  input  logic [ADDR_W-1:0]      sweep_idx,
  input  logic                   set_en,
  input  logic [ADDR_W-1:0]      set_idx,
  input  logic                   clr_en,
  input  logic [ADDR_W-1:0]      clr_idx,
  output logic [(2**ADDR_W)-1:0] pending
);

  always_ff @(posedge CLK) begin
    if (sweep_en) begin
      pending[sweep_idx] <= 1'b0;
    end else begin
      if (clr_en) pending[clr_idx] <= 1'b0;
      if (set_en) pending[set_idx] <= 1'b1;
    end
    // Register 0 can never await a producer.
    pending[0] <= 1'b0;
  end

endmodule

// File: rtl/mips_reg_file_sb.sv
// Register file with pending scoreboard, clear sweep after reset, N read ports.
// Define MIPS_RF_BYPASS_EN to forward same-cycle writes to the read ports.
module mips_reg_file_sb
  import mips_rf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = NUM_RD_DEF
) (
  input  logic                     CLK,
  input  logic                     rst,
  input  logic                     RegWrite,
  input  logic [ADDR_W-1:0]        WriteAddress,
  input  logic [DATA_W-1:0]        DataIn,
  input  logic                     RsvEn,
  input  logic [ADDR_W-1:0]        RsvAddress,
  input  logic [NUM_RD*ADDR_W-1:0] Address,
  output logic [NUM_RD*DATA_W-1:0] DataOut,
  output logic [NUM_RD-1:0]        Pending,
  output logic                     Ready
);

  localparam int DEPTH = 2 ** ADDR_W;

  rf_state_t          state;
  logic [ADDR_W-1:0]  sweep_idx;
  logic [DATA_W-1:0]  mem [DEPTH];
  logic [DEPTH-1:0]   pend;
  logic               run;
  logic               wr_ok;
  logic               rsv_ok;
  logic               sweep_en;

  assign run      = (state == RF_RUN);
  assign wr_ok    = run && RegWrite && (WriteAddress != '0);
  assign rsv_ok   = run && RsvEn && (RsvAddress != '0);
  assign sweep_en = !rst && (state == RF_CLEAR);
  assign Ready    = run;

  always_ff @(posedge CLK) begin
    if (rst) begin
      state     <= RF_CLEAR;
      sweep_idx <= ADDR_W'(1);
    end else if (state == RF_CLEAR) begin
      sweep_idx <= sweep_idx + ADDR_W'(1);
      if (sweep_idx == ADDR_W'(DEPTH - 1)) state <= RF_RUN;
    end
  end

  // Storage is zeroed only by the sweep; index 0 is never stored, reads force 0.
  always_ff @(posedge CLK) begin
    if (sweep_en) begin
      mem[sweep_idx] <= '0;
    end else if (wr_ok) begin
      mem[WriteAddress] <= DataIn;
    end
  end

  mips_rf_scoreboard #(
    .ADDR_W(ADDR_W)
  ) u_scoreboard (
    .CLK      (CLK),
    .sweep_en (sweep_en),
    .sweep_idx(sweep_idx),
    .set_en   (rsv_ok),
    .set_idx  (RsvAddress),
    .clr_en   (wr_ok),
    .clr_idx  (WriteAddress),
    .pending  (pend)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd_data;
    logic              rd_pend;

    assign ra = Address[k*ADDR_W +: ADDR_W];

    always_comb begin
      rd_data = '0;
      rd_pend = 1'b0;
      if (run && (ra != '0)) begin
`ifdef MIPS_RF_BYPASS_EN
        if (wr_ok && (WriteAddress == ra)) begin
          rd_data = DataIn;
          rd_pend = rsv_ok && (RsvAddress == ra);
        end else begin
          rd_data = mem[ra];
          rd_pend = pend[ra];
        end
`else
        rd_data = mem[ra];
        rd_pend = pend[ra];
`endif
      end
    end

    assign DataOut[k*DATA_W +: DATA_W] = rd_data;
    assign Pending[k]                  = rd_pend;
  end

endmodule
